pmp_csr_regs: RTL and testbench

M-mode CSR register bank for the PMP: pmpcfg0..3 and pmpaddr0..15 with WARL legalisation and lock semantics. Sits directly upstream of the combinational PMP checker and drives its packed conf_addr/conf inputs. CSR accesses complete in one cycle with a registered response. A one-cycle update pulse lets the MMU and TLBs flush cached permissions.

---
 rtl/riscv_pkg.sv | 31 +++
 rtl/pmp_cfg_warl.sv | 20 ++
 rtl/pmp_csr_regs.sv | 107 ++++++++++
 tb/tb_pmp_csr_regs.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RISC-V privilege, CSR address and PMP configuration types
package riscv_pkg;
    typedef enum logic [1:0] {
        PRIV_U = 2'b00,
        PRIV_S = 2'b01,
        PRIV_M = 2'b11
    } priv_lvl_t;

    typedef enum logic [1:0] {
        OFF   = 2'b00,
        TOR   = 2'b01,
        NA4   = 2'b10,
        NAPOT = 2'b11
    } pmp_addr_mode_t;

    typedef struct packed {
        logic           x;
        logic           w;
        logic           r;
    } pmpcfg_access_t;

    typedef struct packed {
        logic           locked;
        logic [1:0]     reserved;
        pmp_addr_mode_t addr_mode;
        pmpcfg_access_t access;
    } pmpcfg_t;

    localparam logic [11:0] CSR_PMPCFG0  = 12'h3A0;
    localparam logic [11:0] CSR_PMPADDR0 = 12'h3B0;
endpackage

// File: rtl/pmp_cfg_warl.sv
// pmp_cfg_warl: legalises one pmpcfg byte write against its current value
module pmp_cfg_warl
    import riscv_pkg::*;
(
    input  pmpcfg_t old_i,
    input  pmpcfg_t new_i,
    output pmpcfg_t next_o,
    output logic    changed_o
);
    pmpcfg_t clean;

    always_comb begin
        clean = new_i;
        clean.reserved = 2'b00;
        // W without R is a reserved combination: keep the old byte
        next_o = (old_i.locked || (new_i.access.w && !new_i.access.r)) ? old_i : clean;
    end

    assign changed_o = next_o != old_i;
endmodule

// File: rtl/pmp_csr_regs.sv
// pmp_csr_regs: M-mode pmpcfg/pmpaddr CSR bank with WARL legalisation and locks,
// driving the packed configuration of the downstream PMP checker
module pmp_csr_regs
    import riscv_pkg::*;
#(
    parameter int unsigned NR_ENTRIES = 4,
    parameter int unsigned PMP_LEN    = 32,
    parameter int unsigned XLEN       = 32
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          csr_req_i,
    input  logic                          csr_we_i,
    input  logic [11:0]                   csr_addr_i,
    input  logic [XLEN-1:0]               csr_wdata_i,
    input  logic [1:0]                    priv_lvl_i,
    output logic                          csr_rvalid_o,
    output logic [XLEN-1:0]               csr_rdata_o,
    output logic                          csr_illegal_o,
    output logic [NR_ENTRIES*PMP_LEN-1:0] conf_addr_o,
    output logic [NR_ENTRIES*8-1:0]       conf_o,
    output logic                          pmp_update_o
);
    pmpcfg_t [NR_ENTRIES-1:0]              cfg_q, cfg_d;
    pmpcfg_t [NR_ENTRIES:0]                cfg_nx;
    logic    [NR_ENTRIES-1:0][PMP_LEN-1:0] addr_q, addr_d;
    pmpcfg_t [15:0]                        cfg_all;
    logic    [15:0][PMP_LEN-1:0]           addr_all;
    pmpcfg_t [3:0]                         warl_next;
    logic    [3:0]                         warl_chg;
    logic    [NR_ENTRIES-1:0]              addr_lock;
    logic                                  is_cfg, is_addr, legal, wr, update_d;
    logic                                  rvalid_q, illegal_q, update_q;
    logic    [XLEN-1:0]                    rdata_d, rdata_q;

    assign is_cfg  = csr_addr_i[11:2] == CSR_PMPCFG0[11:2];
    assign is_addr = csr_addr_i[11:4] == CSR_PMPADDR0[11:4];
    assign legal   = (priv_lvl_i == PRIV_M) && (is_cfg || is_addr);
    assign wr      = csr_req_i && csr_we_i && legal;

    // zero-padded views so unimplemented entries read 0 and index uniformly
    always_comb begin
        cfg_all  = '0;
        addr_all = '0;
        cfg_nx   = {8'h00, cfg_q};
        for (int i = 0; i < NR_ENTRIES; i++) begin
            cfg_all[i]   = cfg_q[i];
            addr_all[i]  = addr_q[i];
            addr_lock[i] = cfg_q[i].locked || (cfg_nx[i+1].locked && cfg_nx[i+1].addr_mode == TOR);
        end
    end

    for (genvar k = 0; k < 4; k++) begin : g_warl
        pmp_cfg_warl u_warl (
            .old_i     (cfg_all[{csr_addr_i[1:0], 2'(k)}]),
            .new_i     (pmpcfg_t'(csr_wdata_i[8*k +: 8])),
            .next_o    (warl_next[k]),
            .changed_o (warl_chg[k])
        );
    end

    always_comb begin
        cfg_d    = cfg_q;
        addr_d   = addr_q;
        update_d = 1'b0;
        for (int i = 0; i < NR_ENTRIES; i++) begin
            if (wr && is_cfg && csr_addr_i[1:0] == i[3:2]) begin
                cfg_d[i] = warl_next[i[1:0]];
                update_d = update_d | warl_chg[i[1:0]];
            end
            if (wr && is_addr && csr_addr_i[3:0] == i[3:0] && !addr_lock[i]) begin
                addr_d[i] = csr_wdata_i[PMP_LEN-1:0];
                update_d = update_d | (addr_q[i] != csr_wdata_i[PMP_LEN-1:0]);
            end
        end
    end

    assign rdata_d = !legal ? '0
                   : is_cfg ? XLEN'({cfg_all[{csr_addr_i[1:0], 2'd3}], cfg_all[{csr_addr_i[1:0], 2'd2}],
                                     cfg_all[{csr_addr_i[1:0], 2'd1}], cfg_all[{csr_addr_i[1:0], 2'd0}]})
                   : XLEN'(addr_all[csr_addr_i[3:0]]);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cfg_q     <= '0;
            addr_q    <= '0;
            rvalid_q  <= 1'b0;
            illegal_q <= 1'b0;
            rdata_q   <= '0;
            update_q  <= 1'b0;
        end else begin
            cfg_q     <= cfg_d;
            addr_q    <= addr_d;
            rvalid_q  <= csr_req_i;
            illegal_q <= csr_req_i && !legal;
            rdata_q   <= csr_req_i ? rdata_d : '0;
            update_q  <= update_d;
        end
    end

    assign csr_rvalid_o  = rvalid_q;
    assign csr_illegal_o = illegal_q;
    assign csr_rdata_o   = rdata_q;
    assign pmp_update_o  = update_q;
    assign conf_o        = cfg_q;
    assign conf_addr_o   = addr_q;
endmodule

// File: tb/tb_pmp_csr_regs.sv
// tb_pmp_csr_regs: directed and randomized CSR accesses checked against an
// entry-level reference model of the PMP register bank
module tb_pmp_csr_regs;
    localparam int NR = 4;
    localparam int PL = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           csr_req, csr_we;
    logic [11:0]    csr_addr;
    logic [31:0]    csr_wdata;
    logic [1:0]     priv;
    logic           rvalid, illegal, update;
    logic [31:0]    rdata;
    logic [NR*PL-1:0] conf_addr;
    logic [NR*8-1:0]  conf;

    int checks = 0;
    int errors = 0;

    logic [7:0]  m_cfg [16];
    logic [31:0] m_addr[16];
    logic        exp_illegal, exp_upd;
    logic [31:0] exp_rdata;

    pmp_csr_regs #(.NR_ENTRIES(NR), .PMP_LEN(PL), .XLEN(32)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .csr_req_i    (csr_req),
        .csr_we_i     (csr_we),
        .csr_addr_i   (csr_addr),
        .csr_wdata_i  (csr_wdata),
        .priv_lvl_i   (priv),
        .csr_rvalid_o (rvalid),
        .csr_rdata_o  (rdata),
        .csr_illegal_o(illegal),
        .conf_addr_o  (conf_addr),
        .conf_o       (conf),
        .pmp_update_o (update)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int e = 0; e < 16; e++) begin
            m_cfg[e]  = 8'h00;
            m_addr[e] = 32'h0;
        end
    endtask

    // reference: spec rules applied entry by entry on pre-write state
    task automatic model_access(input bit we, input logic [11:0] addr, input logic [31:0] wd, input logic [1:0] pv);
        logic [7:0] old_cfg[16];
        logic [7:0] nb;
        bit is_cfg, is_addr;
        int e0, e;
        is_cfg  = addr >= 12'h3A0 && addr <= 12'h3A3;
        is_addr = addr >= 12'h3B0 && addr <= 12'h3BF;
        exp_illegal = !(pv == 2'b11 && (is_cfg || is_addr));
        exp_rdata = 32'h0;
        exp_upd = 1'b0;
        if (exp_illegal) return;
        old_cfg = m_cfg;
        e0 = is_cfg ? 4 * int'(addr - 12'h3A0) : int'(addr - 12'h3B0);
        if (is_cfg) begin
            for (int k = 0; k < 4; k++)
                if (e0 + k < NR) exp_rdata[8*k +: 8] = m_cfg[e0+k];
        end else if (e0 < NR) exp_rdata = m_addr[e0];
        if (!we) return;
        if (is_cfg) begin
            for (int k = 0; k < 4; k++) begin
                e = e0 + k;
                nb = wd[8*k +: 8];
                if (e < NR && !old_cfg[e][7] && !(nb[1] && !nb[0])) begin
                    if (m_cfg[e] != (nb & 8'h9F)) exp_upd = 1'b1;
                    m_cfg[e] = nb & 8'h9F;
                end
            end
        end else if (e0 < NR && !old_cfg[e0][7] &&
                     !(e0 + 1 < NR && old_cfg[e0+1][7] && old_cfg[e0+1][4:3] == 2'b01)) begin
            if (m_addr[e0] != wd) exp_upd = 1'b1;
            m_addr[e0] = wd;
        end
    endtask

    task automatic check_conf();
        logic [NR*8-1:0]  ec;
        logic [NR*PL-1:0] ea;
        for (int e = 0; e < NR; e++) begin
            ec[e*8 +: 8]   = m_cfg[e];
            ea[e*PL +: PL] = m_addr[e];
        end
        check("conf", 128'(conf), 128'(ec));
        check("conf_addr", 128'(conf_addr), 128'(ea));
    endtask

    task automatic access(input bit we, input logic [11:0] addr, input logic [31:0] wd, input logic [1:0] pv);
        csr_req = 1'b1;
        csr_we = we;
        csr_addr = addr;
        csr_wdata = wd;
        priv = pv;
        model_access(we, addr, wd, pv);
        @(posedge clk);
        #1;
        check("rvalid", 128'(rvalid), 128'(1'b1));
        check("illegal", 128'(illegal), 128'(exp_illegal));
        check("rdata", 128'(rdata), 128'(exp_rdata));
        check("update", 128'(update), 128'(exp_upd));
        check_conf();
    endtask

    task automatic idle();
        csr_req = 1'b0;
        csr_we = 1'($urandom);
        csr_addr = 12'h3B0;
        csr_wdata = $urandom;
        @(posedge clk);
        #1;
        check("idle_rvalid", 128'(rvalid), 128'(1'b0));
        check("idle_update", 128'(update), 128'(1'b0));
        check_conf();
    endtask

    task automatic do_reset(input bit with_req);
        rst = 1'b1;
        csr_req = with_req;
        csr_we = 1'b1;
        csr_addr = 12'h3B0;
        csr_wdata = 32'hDEAD_BEEF;
        priv = 2'b11;
        @(posedge clk);
        #1;
        rst = 1'b0;
        csr_req = 1'b0;
        model_clear();
        check("rst_rvalid", 128'(rvalid), 128'(1'b0));
        check("rst_rdata", 128'(rdata), 128'(0));
        check("rst_illegal", 128'(illegal), 128'(1'b0));
        check("rst_update", 128'(update), 128'(1'b0));
        check_conf();
    endtask

    initial begin
        logic [11:0] a;
        logic [31:0] wd;
        logic [1:0]  pv;
        rst = 1'b1;
        csr_req = 1'b0;
        csr_we = 1'b0;
        csr_addr = '0;
        csr_wdata = '0;
        priv = 2'b11;
        model_clear();
        do_reset(1'b0);
        access(0, 12'h3A0, 0, 2'b11);
        access(0, 12'h3B0, 0, 2'b11);
        idle();
        access(1, 12'h3A0, 32'h0000_0F1F, 2'b11);
        access(0, 12'h3A0, 0, 2'b11);
        access(1, 12'h3A0, 32'h0000_0F1F, 2'b11);
        access(1, 12'h3A0, 32'h0000_0F02, 2'b11);
        access(1, 12'h3A0, 32'h0000_0F9F, 2'b11);
        access(1, 12'h3A0, 32'h0000_0F00, 2'b11);
        access(0, 12'h3A0, 0, 2'b11);
        do_reset(1'b0);
        access(1, 12'h3B0, 32'h0000_5555, 2'b11);
        access(1, 12'h3A0, 32'h0000_8800, 2'b11);
        access(1, 12'h3B0, 32'h0000_1234, 2'b11);
        access(0, 12'h3B0, 0, 2'b11);
        access(1, 12'h3B1, 32'h0000_4444, 2'b11);
        access(1, 12'h3B2, 32'h0000_6666, 2'b11);
        access(0, 12'h3B2, 0, 2'b11);
        access(1, 12'h3B3, 32'h0000_7777, 2'b00);
        access(0, 12'h3B0, 0, 2'b00);
        access(1, 12'h3C5, 32'hFFFF_FFFF, 2'b11);
        access(1, 12'h3B8, 32'h0000_FFFF, 2'b11);
        access(0, 12'h3B8, 0, 2'b11);
        access(1, 12'h3A1, 32'hFFFF_FFFF, 2'b11);
        access(1, 12'h3B3, 32'hCAFE_F00D, 2'b11);
        do_reset(1'b1);
        idle();
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 49) == 0) begin
                do_reset(1'($urandom));
                continue;
            end
            if ($urandom_range(0, 7) == 0) begin
                idle();
                continue;
            end
            case ($urandom_range(0, 9))
                0, 1, 2, 3: a = 12'h3A0 + 12'($urandom_range(0, 3));
                9:          a = 12'($urandom);
                default:    a = 12'h3B0 + 12'($urandom_range(0, 1) ? $urandom_range(0, 4) : $urandom_range(0, 15));
            endcase
            wd = $urandom_range(0, 3) == 0 ? 32'h0000_1234 : $urandom;
            if (a[11:4] == 8'h3A) begin
                for (int k = 0; k < 4; k++)
                    if ($urandom_range(0, 15) != 0) wd[8*k+7] = 1'b0;
            end
            pv = $urandom_range(0, 7) == 0 ? 2'($urandom_range(0, 2)) : 2'b11;
            access(1'($urandom), a, wd, pv);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
